// File: rtl/process_scheduler.sv
// process_scheduler
//   Round-robin process-slot scheduler. It holds a table of NPROC process slots.
//   Each slot has a saved PC, a quantum extension and a ready bit. On a
//   context-change request from the PC stage, the scheduler saves the preempted
//   PC. It then picks the next ready slot, searching round-robin from
//   cur_pid+1, and hands that slot's PC and quantum back to the PC stage.
//
// Ports
//   CLK            clock, all state changes on posedge
//   reset          synchronous, active-low reset
//   ctx_switch     one-cycle context-change request (honoured only in RUN)
//   saved_pc       PC of the preempted process, valid with ctx_switch
//   proc_end       current process terminated; its slot is retired at the next save
//   load_valid     OS slot create/overwrite strobe (accepted in every state)
//   load_pid       slot written by load
//   load_pc        start PC for load
//   load_quantum   quantum extension for load
//   next_pc        restore PC; stable until the next restore
//   next_quantum   restore quantum; stable until the next restore
//   restore_valid  one-cycle strobe qualifying next_pc/next_quantum
//   cur_pid        running slot
//   busy           high while in SAVE, SELECT or RESTORE
//   idle           high while in IDLE (no ready slot)
//   stateDbg       raw FSM state encoding, for checkers
//
// Handshake: restore_valid is a pure one-cycle strobe with no ready or back-pressure.
// next_pc, next_quantum and cur_pid are valid whenever restore_valid is high.
// The PC stage must take them in that cycle. ctx_switch and load_valid are also
// single-cycle strobes that are never stalled. ctx_switch is silently dropped
// outside RUN.

module process_scheduler #(
    parameter int NPROC = 4,
    parameter int PIDW  = 2
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            ctx_switch,
    input  logic [31:0]     saved_pc,
    input  logic            proc_end,
    input  logic            load_valid,
    input  logic [PIDW-1:0] load_pid,
    input  logic [31:0]     load_pc,
    input  logic [31:0]     load_quantum,
    output logic [31:0]     next_pc,
    output logic [31:0]     next_quantum,
    output logic            restore_valid,
    output logic [PIDW-1:0] cur_pid,
    output logic            busy,
    output logic            idle,
    output logic [2:0]      stateDbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        RESTORE = 3'd2,
        RUN     = 3'd3,
        SAVE    = 3'd4
    } stateT;

    stateT             state;
    logic [31:0]       pcTab [NPROC];
    logic [31:0]       qTab  [NPROC];
    logic [NPROC-1:0]  readyBits;
    logic [31:0]       savedPcReg;
    logic              pendEnd;

    logic              selHit;
    logic [PIDW-1:0]   selPid;
    logic [PIDW-1:0]   cand;
    logic              endNow;

    // Round-robin search. Offsets 1..NPROC from cur_pid, wrapping modulo NPROC.
    // Offset NPROC truncates to cur_pid, so the current slot is checked last.
    always_comb begin
        selHit = 1'b0;
        selPid = cur_pid;
        cand   = cur_pid;
        for (int off = 1; off <= NPROC; off++) begin
            cand = cur_pid + PIDW'(off);
            if (!selHit && readyBits[cand]) begin
                selHit = 1'b1;
                selPid = cand;
            end
        end
    end

    // A proc_end that arrives in the SAVE cycle itself still retires the slot.
    assign endNow   = pendEnd || proc_end;

    assign busy     = (state == SAVE) || (state == SELECT) || (state == RESTORE);
    assign idle     = (state == IDLE);
    assign stateDbg = state;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state         <= IDLE;
            readyBits     <= '0;
            cur_pid       <= '0;
            next_pc       <= '0;
            next_quantum  <= '0;
            restore_valid <= 1'b0;
            savedPcReg    <= '0;
            pendEnd       <= 1'b0;
            for (int i = 0; i < NPROC; i++) begin
                pcTab[i] <= '0;
                qTab[i]  <= '0;
            end
        end else begin
            restore_valid <= 1'b0;

            // Slot table. A load to the running slot wins over that slot's save.
            for (int i = 0; i < NPROC; i++) begin
                if (load_valid && (load_pid == PIDW'(i))) begin
                    pcTab[i]     <= load_pc;
                    qTab[i]      <= load_quantum;
                    readyBits[i] <= 1'b1;
                end else if ((state == SAVE) && (cur_pid == PIDW'(i))) begin
                    if (endNow) begin
                        readyBits[i] <= 1'b0;
                    end else begin
                        pcTab[i] <= savedPcReg;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (|readyBits) begin
                        state <= SELECT;
                    end
                end
                RUN: begin
                    if (proc_end) begin
                        pendEnd <= 1'b1;
                    end
                    if (ctx_switch) begin
                        savedPcReg <= saved_pc;
                        state      <= SAVE;
                    end
                end
                SAVE: begin
                    if (proc_end) begin
                        pendEnd <= 1'b1;
                    end
                    state <= SELECT;
                end
                SELECT: begin
                    if (selHit) begin
                        cur_pid <= selPid;
                        pendEnd <= 1'b0;
                        state   <= RESTORE;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESTORE: begin
                    next_pc       <= pcTab[cur_pid];
                    next_quantum  <= qTab[cur_pid];
                    restore_valid <= 1'b1;
                    state         <= RUN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_process_scheduler.sv
// tb_process_scheduler
//   Directed testbench for process_scheduler (NPROC=4, PIDW=2).
//   Each driver task pushes the restore it expects into exp_q. The monitor
//   pops and compares an entry on every cycle where restore_valid is high.
//   Timing and status checks are made inline by the directed sequence.

module tb_process_scheduler;

    localparam int NPROC = 4;
    localparam int PIDW  = 2;
    localparam int W     = 64 + PIDW;

    logic            CLK;
    logic            reset;
    logic            ctx_switch;
    logic [31:0]     saved_pc;
    logic            proc_end;
    logic            load_valid;
    logic [PIDW-1:0] load_pid;
    logic [31:0]     load_pc;
    logic [31:0]     load_quantum;
    logic [31:0]     next_pc;
    logic [31:0]     next_quantum;
    logic            restore_valid;
    logic [PIDW-1:0] cur_pid;
    logic            busy;
    logic            idle;
    logic [2:0]      stateDbg;

    logic [W-1:0]    exp_q[$];
    int              testsRun  = 0;
    int              failCount = 0;

    process_scheduler #(.NPROC(NPROC), .PIDW(PIDW)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .ctx_switch    (ctx_switch),
        .saved_pc      (saved_pc),
        .proc_end      (proc_end),
        .load_valid    (load_valid),
        .load_pid      (load_pid),
        .load_pc       (load_pc),
        .load_quantum  (load_quantum),
        .next_pc       (next_pc),
        .next_quantum  (next_quantum),
        .restore_valid (restore_valid),
        .cur_pid       (cur_pid),
        .busy          (busy),
        .idle          (idle),
        .stateDbg      (stateDbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetVals(input string tag);
        check({tag, "_next_pc"},      64'(next_pc),       64'd0);
        check({tag, "_next_quantum"}, 64'(next_quantum),  64'd0);
        check({tag, "_restore_vld"},  64'(restore_valid), 64'd0);
        check({tag, "_cur_pid"},      64'(cur_pid),       64'd0);
        check({tag, "_busy"},         64'(busy),          64'd0);
        check({tag, "_idle"},         64'(idle),          64'd1);
        check({tag, "_state"},        64'(stateDbg),      64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (restore_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                testsRun++;
                failCount++;
                $display("FAIL unexpected_restore: got restore_valid=1 pc=0x%0h pid=%0d, required no restore",
                         next_pc, cur_pid);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("restore_pc",      64'(next_pc),      64'(e[W-1:W-32]));
                check("restore_quantum", 64'(next_quantum), 64'(e[W-33:PIDW]));
                check("restore_pid",     64'(cur_pid),      64'(e[PIDW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic doReset(input string tag);
        reset = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkResetVals(tag);
        reset = 1'b1;
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] q, input logic [PIDW-1:0] pid);
        exp_q.push_back({pc, q, pid});
    endtask

    task automatic loadSlot(input logic [PIDW-1:0] pid, input logic [31:0] pc, input logic [31:0] q);
        load_valid   = 1'b1;
        load_pid     = pid;
        load_pc      = pc;
        load_quantum = q;
        @(posedge CLK);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic ctxSwitch(input logic [31:0] pc);
        ctx_switch = 1'b1;
        saved_pc   = pc;
        @(posedge CLK);
        #1;
        ctx_switch = 1'b0;
    endtask

    task automatic procEndPulse();
        proc_end = 1'b1;
        @(posedge CLK);
        #1;
        proc_end = 1'b0;
    endtask

    // Samples restore_valid on `total` consecutive negedges; it must be high only on the hitAt-th.
    task automatic checkPulse(input string name, input int hitAt, input int total);
        for (int i = 1; i <= total; i++) begin
            @(negedge CLK);
            check($sformatf("%s_rv%0d", name, i), 64'(restore_valid), 64'(i == hitAt));
        end
    endtask

    task automatic waitRun(input string name, input int budget);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge CLK);
            n++;
            if (!busy && !idle) ok = 1'b1;
        end
        check({name, "_reach_run"}, 64'(ok), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset        = 1'b0;
        ctx_switch   = 1'b0;
        saved_pc     = '0;
        proc_end     = 1'b0;
        load_valid   = 1'b0;
        load_pid     = '0;
        load_pc      = '0;
        load_quantum = '0;

        // Single load into an idle scheduler.
        doReset("rst1");
        pushExp(32'h100, 32'd5, 2'd1);
        loadSlot(2'd1, 32'h100, 32'd5);
        @(negedge CLK);
        check("s1_idle_after_load", 64'(idle), 64'd1);
        @(negedge CLK);
        check("s1_busy_select", 64'(busy), 64'd1);
        @(negedge CLK);
        check("s1_busy_restore", 64'(busy), 64'd1);
        check("s1_rv_restore",   64'(restore_valid), 64'd0);
        @(negedge CLK);
        check("s1_rv_pulse",  64'(restore_valid), 64'd1);
        check("s1_cur_pid",   64'(cur_pid), 64'd1);
        @(negedge CLK);
        check("s1_rv_drop",   64'(restore_valid), 64'd0);
        repeat (3) @(negedge CLK);
        check("s1_hold_pc", 64'(next_pc),      64'h100);
        check("s1_hold_q",  64'(next_quantum), 64'd5);

        // Three slots, round-robin rotation, saved PC reused later.
        doReset("rst2");
        pushExp(32'h20, 32'd2, 2'd1);
        loadSlot(2'd0, 32'h10, 32'd1);
        loadSlot(2'd1, 32'h20, 32'd2);
        loadSlot(2'd2, 32'h30, 32'd3);
        waitRun("s2_start", 10);
        pushExp(32'h30, 32'd3, 2'd2);
        ctxSwitch(32'h24);
        checkPulse("s2_to2", 4, 5);
        pushExp(32'h10, 32'd1, 2'd0);
        ctxSwitch(32'h2A4);
        checkPulse("s2_to0", 4, 5);
        pushExp(32'h24, 32'd2, 2'd1);
        ctxSwitch(32'h14);
        checkPulse("s2_to1", 4, 5);
        pushExp(32'h2A4, 32'd3, 2'd2);
        ctxSwitch(32'h28);
        checkPulse("s2_back2", 4, 5);

        // Terminated last slot: retired, scheduler goes idle.
        doReset("rst3");
        pushExp(32'h300, 32'd7, 2'd3);
        loadSlot(2'd3, 32'h300, 32'd7);
        checkPulse("s3_start", 4, 5);
        procEndPulse();
        ctxSwitch(32'h999);
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            check($sformatf("s3_no_rv%0d", i), 64'(restore_valid), 64'd0);
            if (i == 3 || i == 6) begin
                check($sformatf("s3_idle%0d", i), 64'(idle), 64'd1);
            end
        end
        check("s3_busy_end", 64'(busy), 64'd0);

        // Only slot 0 ready: it reselects itself with the saved PC.
        doReset("rst4");
        pushExp(32'h8, 32'd9, 2'd0);
        loadSlot(2'd0, 32'h8, 32'd9);
        checkPulse("s4_start", 4, 5);
        pushExp(32'h40, 32'd9, 2'd0);
        ctxSwitch(32'h40);
        checkPulse("s4_self", 4, 5);

        // Load into the running slot during SAVE beats the save.
        doReset("rst5");
        pushExp(32'h100, 32'd4, 2'd1);
        loadSlot(2'd1, 32'h100, 32'd4);
        checkPulse("s5_start", 4, 5);
        pushExp(32'h500, 32'd6, 2'd1);
        ctx_switch = 1'b1;
        saved_pc   = 32'h77;
        @(posedge CLK);
        #1;
        ctx_switch   = 1'b0;
        load_valid   = 1'b1;
        load_pid     = 2'd1;
        load_pc      = 32'h500;
        load_quantum = 32'd6;
        @(posedge CLK);
        #1;
        load_valid = 1'b0;
        checkPulse("s5_load_wins", 3, 4);
        pushExp(32'h600, 32'd6, 2'd1);
        ctxSwitch(32'h600);
        checkPulse("s5_next_save", 4, 5);

        // Reset during SELECT aborts the restore; inputs ignored under reset.
        doReset("rst6");
        loadSlot(2'd2, 32'h220, 32'd3);
        @(negedge CLK);
        @(negedge CLK);
        check("s6_busy_select", 64'(busy), 64'd1);
        reset        = 1'b0;
        load_valid   = 1'b1;
        load_pid     = 2'd1;
        load_pc      = 32'hABC;
        load_quantum = 32'd1;
        ctx_switch   = 1'b1;
        proc_end     = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            checkResetVals($sformatf("s6_rst%0d", i));
        end
        reset      = 1'b1;
        load_valid = 1'b0;
        ctx_switch = 1'b0;
        proc_end   = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            check($sformatf("s6_after_rv%0d", i), 64'(restore_valid), 64'd0);
            check($sformatf("s6_after_idle%0d", i), 64'(idle), 64'd1);
        end

        // Every expected restore must have been observed.
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
